store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores with youngest-entry coalescing,
// byte-granular load forwarding and a two-state drain engine towards the dcache.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [ADDR_W-1:0]        st_addr,
   input  logic [DATA_W-1:0]        st_data,
   input  logic [DATA_W/8-1:0]      st_be,
   input  logic [ADDR_W-1:0]        ld_addr,
   input  logic [DATA_W/8-1:0]      ld_be,
   output logic                     ld_hit,
   output logic                     ld_partial,
   output logic [DATA_W-1:0]        ld_data,
   output logic                     mem_write,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   output logic [DATA_W/8-1:0]      mem_be,
   input  logic                     mem_resp,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     o_dbg_state
);

   localparam int BE_W  = DATA_W / 8;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BO_W  = $clog2(BE_W);
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'((1 << BO_W) - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_WRITE = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Addresses are kept word-aligned so they can go straight out on mem_addr.
   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [BE_W-1:0]   r_be   [DEPTH];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;

   logic [PTR_W-1:0]  w_young;
   logic [ADDR_W-1:0] w_st_word;
   logic [ADDR_W-1:0] w_ld_word;
   logic              w_coalesce_ok;
   logic              w_accept;
   logic              w_coalesce;
   logic              w_alloc;
   logic              w_pop;
   logic [CNT_W-1:0]  w_count_nxt;
   logic [PTR_W-1:0]  w_idx;
   logic [BE_W-1:0]   w_cov;
   logic [DATA_W-1:0] w_fwd;

   function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_d,
                                                 input logic [DATA_W-1:0] new_d,
                                                 input logic [BE_W-1:0]   be);
      logic [DATA_W-1:0] res;
      res = old_d;
      for (int b = 0; b < BE_W; b++) begin
         if (be[b]) res[b*8 +: 8] = new_d[b*8 +: 8];
      end
      return res;
   endfunction

   assign w_young   = r_tail - PTR_W'(1);
   assign w_st_word = st_addr & WORD_MASK;
   assign w_ld_word = ld_addr & WORD_MASK;
   assign w_pop     = (r_state == S_WRITE) && mem_resp;

   // The entry in flight to the dcache must stay frozen, so it is never a merge target.
   assign w_coalesce_ok = (r_count != '0) && (r_addr[w_young] == w_st_word) &&
                          !((r_state == S_WRITE) && (w_young == r_head));

   assign st_ready   = (r_count < FULL_CNT) || w_coalesce_ok;
   assign w_accept   = st_valid && st_ready;
   assign w_coalesce = w_accept && w_coalesce_ok;
   assign w_alloc    = w_accept && !w_coalesce_ok;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_alloc, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
            r_be[i]   <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_alloc) begin
            r_addr[r_tail] <= w_st_word;
            r_data[r_tail] <= f_merge('0, st_data, st_be);
            r_be[r_tail]   <= st_be;
            r_tail         <= r_tail + PTR_W'(1);
         end
         if (w_coalesce) begin
            r_data[w_young] <= f_merge(r_data[w_young], st_data, st_be);
            r_be[w_young]   <= r_be[w_young] | st_be;
         end
         if (w_pop) r_head <= r_head + PTR_W'(1);
         r_count <= w_count_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      mem_write   = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_be      = '0;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) w_state_nxt = S_WRITE;
         end
         S_WRITE: begin
            mem_write = 1'b1;
            mem_addr  = r_addr[r_head];
            mem_wdata = r_data[r_head];
            mem_be    = r_be[r_head];
            if (w_pop) w_state_nxt = (w_count_nxt != '0) ? S_WRITE : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Walk oldest to youngest so the youngest matching byte wins each lane.
   always_comb begin
      w_cov = '0;
      w_fwd = '0;
      w_idx = r_head;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_head + PTR_W'(i);
         if ((CNT_W'(i) < r_count) && (r_addr[w_idx] == w_ld_word)) begin
            for (int b = 0; b < BE_W; b++) begin
               if (r_be[w_idx][b] && ld_be[b]) begin
                  w_cov[b]         = 1'b1;
                  w_fwd[b*8 +: 8]  = r_data[w_idx][b*8 +: 8];
               end
            end
         end
      end
   end

   assign ld_hit      = (ld_be != '0) && (w_cov == ld_be);
   assign ld_partial  = (w_cov != '0) && !ld_hit;
   assign ld_data     = w_fwd;
   assign count       = r_count;
   assign empty       = (r_count == '0);
   assign o_dbg_state = r_state;

endmodule
